vector_relu_writeback: RTL and testbench
========================================

VECTOR_RELU_WRITEBACK -- requirements
Module: vector_relu_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 16, lane width, IEEE-754 half precision.
REQ-002 Parameter NUM_UNITS, default 16, number of lanes.
REQ-003 Parameter ADDR_WIDTH, default 8, buffer write-address width.
REQ-004 Parameter RELU_EN, default 1; 1 = apply ReLU, 0 = pass data unchanged.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 start  input  1  level request; sampled only in IDLE.
REQ-008 active_units  input  NUM_UNITS  lane mask; bit i = lane i valid.
REQ-009 In_x  input  DATA_WIDTH x NUM_UNITS (unpacked [0:NUM_UNITS-1])  vector from bias-add stage.
REQ-010 base_addr  input  ADDR_WIDTH  buffer address for first written lane.
REQ-011 wr_en  output  1  write request to unified buffer.
REQ-012 wr_addr  output  ADDR_WIDTH  write address.
REQ-013 wr_data  output  DATA_WIDTH  write data.
REQ-014 wr_ready  input  1  buffer accepts the write when high together with wr_en.
REQ-015 busy  output  1  high in CAPTURE-free WRITE state only.
REQ-016 ready  output  1  completion flag, high in DONE only.
REQ-017 num_written  output  $clog2(NUM_UNITS+1)  count of writes completed in current/last job.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, DONE; outputs wr_en, busy, ready SHALL decode from state only (no start/wr_ready combinational path except wr_en gating none).
REQ-019 IDLE & start at edge: capture In_x (ReLU applied per lane), active_units into pending mask, base_addr into address counter, clear num_written; go WRITE if mask nonzero, else DONE.
REQ-020 ReLU (RELU_EN=1): lane with sign bit 1 SHALL become 16'h0000 (covers -0, negatives, negative NaN); sign bit 0 passes unchanged (incl. +Inf, +NaN).
REQ-021 Inputs In_x, active_units, base_addr SHALL be ignored outside the capture edge.
REQ-022 WRITE: wr_en=1; wr_data = captured lane at lowest set bit of pending mask; wr_addr = address counter.
REQ-023 Writes SHALL be compacted: k-th active lane (ascending index) goes to base_addr+k; inactive lanes consume no cycles.
REQ-024 Handshake edge (wr_en & wr_ready): clear that mask bit, address counter +1, num_written +1; wr_en/addr/data SHALL hold stable while wr_ready low.
REQ-025 Handshake clearing last pending bit: next state DONE.
REQ-026 Address counter SHALL wrap modulo 2^ADDR_WIDTH (base 8'hFE, 3 lanes -> FE, FF, 00).
REQ-027 DONE: ready=1; stay while start=1; go IDLE on first edge with start=0.
REQ-028 start asserted in WRITE or DONE SHALL NOT restart or recapture.
REQ-029 Latency, wr_ready constantly 1, N active lanes: start edge t0; wr_en cycles t0+1..t0+N; ready from t0+N+1 (N=0: ready at t0+1).
REQ-030 In IDLE/DONE, wr_data and wr_addr SHALL hold last values; wr_en=0.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, wr_en=0, busy=0, ready=0, wr_addr=0, wr_data=0, num_written=0, pending mask and captured lanes 0.
REQ-032 reset asserted mid-WRITE SHALL abort the job without further writes; after release, block waits in IDLE for start.
REQ-033 start high on the first edge after reset release SHALL be honoured as a normal capture.

Verification
REQ-034 mask 16'hFFFF, In_x[i]=i odd ? 16'hBC00 : 16'h3C00, base 8'h10, wr_ready=1 -> 16 writes addr 10..1F, data 3C00 even / 0000 odd, ready at t0+17, num_written=16.
REQ-035 mask 16'h8005, base 8'hFE -> writes lane0@FE, lane2@FF, lane15@00, no gaps, num_written=3.
REQ-036 mask 16'h0000, start -> no wr_en, ready at t0+1, num_written=0; start held 5 cycles -> ready held, drop start -> IDLE.
REQ-037 mask 16'h000F, wr_ready low 3 cycles on 2nd write -> wr_en/addr/data stable 4 cycles, total 4 writes, order preserved.
REQ-038 reset pulsed low after 2nd of 8 writes -> wr_en falls asynchronously, all outputs 0; new start with RELU_EN=0, In_x=16'h8001 -> data 8001 written.

Source files
------------

// File: rtl/vector_relu_writeback.sv
// Captures a bias-added vector, optionally applies ReLU per lane, and writes the
// active lanes to a unified buffer at consecutive addresses with a ready/valid handshake.
module vector_relu_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RELU_EN    = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [NUM_UNITS-1:0]                 active_units,
  input  logic [DATA_WIDTH-1:0]                In_x [0:NUM_UNITS-1],
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  output logic                                 wr_en,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 wr_ready,
  output logic                                 busy,
  output logic                                 ready,
  output logic [$clog2(NUM_UNITS+1)-1:0]       num_written
);

  localparam int CNT_W = $clog2(NUM_UNITS + 1);
  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [NUM_UNITS-1:0]  MASK_ONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_UNITS-1:0]    mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   lanes_q [0:NUM_UNITS-1];
  logic [DATA_WIDTH-1:0]   lanes_d [0:NUM_UNITS-1];
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]        num_q, num_d;

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
    if ((RELU_EN != 0) && x[DATA_WIDTH-1])
      return '0;
    return x;
  endfunction

  function automatic logic [IDX_W-1:0] low_idx(input logic [NUM_UNITS-1:0] m);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (m[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // addr_q/data_q double as the write-port registers: they are loaded with the
  // next lane to present, and simply hold the last written values once idle.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    lanes_d = lanes_q;
    addr_d  = addr_q;
    data_d  = data_q;
    num_d   = num_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned i = 0; i < NUM_UNITS; i++)
            lanes_d[i] = relu(In_x[i]);
          mask_d = active_units;
          num_d  = '0;
          if (|active_units) begin
            state_d = WRITE;
            addr_d  = base_addr;
            data_d  = relu(In_x[low_idx(active_units)]);
          end else begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (wr_ready) begin
          // mask & (mask - 1) retires exactly the lowest pending lane
          mask_d = mask_q & (mask_q - MASK_ONE);
          num_d  = num_q + CNT_ONE;
          if (mask_d == '0) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + ADDR_ONE;
            data_d = lanes_q[low_idx(mask_d)];
          end
        end
      end
      DONE: begin
        if (!start)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      num_q   <= '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++)
        lanes_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      lanes_q <= lanes_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      num_q   <= num_d;
    end
  end

  assign wr_en       = (state_q == WRITE);
  assign busy        = (state_q == WRITE);
  assign ready       = (state_q == DONE);
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign num_written = num_q;

endmodule

// File: tb/tb_vector_relu_writeback.sv
// Directed bench for vector_relu_writeback: one ReLU instance and one pass-through
// instance share all stimulus; expectations are hand-computed constants.
module tb_vector_relu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] active_units;
  logic [15:0] in_x [0:15];
  logic [7:0]  base_addr;
  logic        wr_ready;

  logic        wr_en,   wr_en_n;
  logic [7:0]  wr_addr, wr_addr_n;
  logic [15:0] wr_data, wr_data_n;
  logic        busy,    busy_n;
  logic        ready,   ready_n;
  logic [4:0]  num_written, num_written_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vector_relu_writeback #(
    .DATA_WIDTH(16), .NUM_UNITS(16), .ADDR_WIDTH(8), .RELU_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .active_units(active_units),
    .In_x(in_x), .base_addr(base_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .ready(ready),
    .num_written(num_written)
  );

  vector_relu_writeback #(
    .DATA_WIDTH(16), .NUM_UNITS(16), .ADDR_WIDTH(8), .RELU_EN(0)
  ) dut_nr (
    .clk(clk), .reset(reset), .start(start), .active_units(active_units),
    .In_x(in_x), .base_addr(base_addr), .wr_en(wr_en_n), .wr_addr(wr_addr_n),
    .wr_data(wr_data_n), .wr_ready(wr_ready), .busy(busy_n), .ready(ready_n),
    .num_written(num_written_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [7:0] a, input logic [15:0] d);
    chk({tag, "_en"},   32'(wr_en), 32'(en));
    chk({tag, "_busy"}, 32'(busy),  32'(en));
    chk({tag, "_addr"}, 32'(wr_addr), 32'(a));
    chk({tag, "_data"}, 32'(wr_data), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; active_units = '0; base_addr = '0; wr_ready = 1'b1;
    for (int i = 0; i < 16; i++) in_x[i] = 16'h0;
    #2;
    chk_wr("rst", 1'b0, 8'h00, 16'h0000);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_num",   32'(num_written), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("idle_ready", 32'(ready), 32'd0);

    // Full mask, alternating +1.0 / -1.0
    for (int i = 0; i < 16; i++) in_x[i] = (i % 2 == 1) ? 16'hBC00 : 16'h3C00;
    active_units = 16'hFFFF; base_addr = 8'h10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) in_x[i] = 16'h7FFF;
    active_units = 16'h0001; base_addr = 8'hAA;
    for (int k = 0; k < 16; k++) begin
      chk_wr($sformatf("full%0d", k), 1'b1, 8'(8'h10 + k), (k % 2 == 1) ? 16'h0000 : 16'h3C00);
      chk($sformatf("full%0d_ready", k), 32'(ready), 32'd0);
      tick();
    end
    chk_wr("full_done", 1'b0, 8'h1F, 16'h0000);
    chk("full_ready", 32'(ready), 32'd1);
    chk("full_num", 32'(num_written), 32'd16);
    tick();
    chk("full_idle", 32'(ready), 32'd0);

    // Sparse mask with address wrap
    for (int i = 0; i < 16; i++) in_x[i] = 16'h1000 + 16'(i);
    active_units = 16'h8005; base_addr = 8'hFE; start = 1'b1;
    tick();
    start = 1'b0;
    chk_wr("wrap0", 1'b1, 8'hFE, 16'h1000); tick();
    chk_wr("wrap1", 1'b1, 8'hFF, 16'h1002); tick();
    chk_wr("wrap2", 1'b1, 8'h00, 16'h100F); tick();
    chk("wrap_ready", 32'(ready), 32'd1);
    chk("wrap_num", 32'(num_written), 32'd3);
    chk("wrap_en", 32'(wr_en), 32'd0);
    tick();

    // Empty mask, start held through DONE
    active_units = 16'h0000; base_addr = 8'h55; start = 1'b1;
    tick();
    chk("empty_ready", 32'(ready), 32'd1);
    chk_wr("empty", 1'b0, 8'h00, 16'h100F);
    chk("empty_num", 32'(num_written), 32'd0);
    active_units = 16'h00FF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("hold%0d_ready", k), 32'(ready), 32'd1);
      chk($sformatf("hold%0d_en", k), 32'(wr_en), 32'd0);
    end
    start = 1'b0;
    tick();
    chk("empty_idle_ready", 32'(ready), 32'd0);
    chk("empty_idle_busy",  32'(busy), 32'd0);

    // Backpressure on the second write
    for (int i = 0; i < 16; i++) in_x[i] = 16'h2000 + 16'(i);
    active_units = 16'h000F; base_addr = 8'h40; start = 1'b1;
    tick();
    start = 1'b0;
    chk_wr("bp0", 1'b1, 8'h40, 16'h2000);
    tick();
    wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_wr($sformatf("bp_stall%0d", k), 1'b1, 8'h41, 16'h2001);
      tick();
    end
    wr_ready = 1'b1;
    chk_wr("bp_stall3", 1'b1, 8'h41, 16'h2001);
    chk("bp_num_stall", 32'(num_written), 32'd1);
    tick();
    chk_wr("bp2", 1'b1, 8'h42, 16'h2002); tick();
    chk_wr("bp3", 1'b1, 8'h43, 16'h2003); tick();
    chk("bp_ready", 32'(ready), 32'd1);
    chk("bp_num", 32'(num_written), 32'd4);
    tick();

    // Reset mid-job, then pass-through instance writes a negative value
    for (int i = 0; i < 16; i++) in_x[i] = 16'h8001;
    active_units = 16'h00FF; base_addr = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    chk_wr("ab0", 1'b1, 8'h20, 16'h0000);
    chk("ab0_nr_data", 32'(wr_data_n), 32'h8001);
    tick(); tick();
    chk("ab_num2", 32'(num_written), 32'd2);
    chk("ab_addr2", 32'(wr_addr), 32'h22);
    reset = 1'b0;
    #1;
    chk_wr("ab_rst", 1'b0, 8'h00, 16'h0000);
    chk("ab_rst_ready", 32'(ready), 32'd0);
    chk("ab_rst_num", 32'(num_written), 32'd0);
    chk("ab_rst_nr_en", 32'(wr_en_n), 32'd0);
    chk("ab_rst_nr_data", 32'(wr_data_n), 32'h0);
    tick();
    chk("ab_rst_hold_en", 32'(wr_en), 32'd0);
    reset = 1'b1;
    active_units = 16'h0001; base_addr = 8'h30; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nr_en",   32'(wr_en_n),   32'd1);
    chk("nr_addr", 32'(wr_addr_n), 32'h30);
    chk("nr_data", 32'(wr_data_n), 32'h8001);
    chk("relu_data", 32'(wr_data), 32'h0000);
    tick();
    chk("nr_ready", 32'(ready_n), 32'd1);
    chk("nr_num", 32'(num_written_n), 32'd1);
    chk("nr_idle_en", 32'(wr_en_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
